sfifo_rr_sched: RTL



---
 rtl/sfifo_rr_sched.sv | 115 +++++++++++
 1 files changed

// File: rtl/sfifo_rr_sched.sv
// sfifo_rr_sched: round-robin burst-limited drain of NSRC sfifos into one valid/ready stream; define SFIFO_RR_SCHED_PRIO_EN to add src_prio priority class
module sfifo_rr_sched #(
  parameter int SELW  = 2,
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [(1<<SELW)-1:0]         src_empty,
`ifdef SFIFO_RR_SCHED_PRIO_EN
  input  logic [(1<<SELW)-1:0]         src_prio,
`endif
  output logic [(1<<SELW)-1:0]         src_read,
  input  logic [(1<<SELW)*WIDTH-1:0]   src_rdata,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [SELW-1:0]              out_src,
  output logic                         busy
);
  localparam int NSRC = 1 << SELW;
  typedef enum logic [1:0] {IDLE, FETCH, CAPT, HOLD} state_t;
  state_t            state_q, state_d;
  logic [SELW-1:0]   ptr_q, ptr_d, sel_q, sel_d, hit, idx;
  logic [7:0]        cnt_q, cnt_d, cnt_inc;
  logic [NSRC-1:0]   src_read_q, src_read_d, mask;
  logic              out_valid_q, out_valid_d, busy_q, busy_d, found;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SELW-1:0]   out_src_q, out_src_d;
  // candidate search: continue the current burst, else first eligible source rotating from ptr
  always_comb begin
`ifdef SFIFO_RR_SCHED_PRIO_EN
    mask = |(~src_empty & src_prio) ? (~src_empty & src_prio) : ~src_empty;
`else
    mask = ~src_empty;
`endif
    found = 1'b0;
    hit = ptr_q;
    idx = ptr_q;
    for (int k = 0; k < NSRC; k++) begin
      idx = ptr_q + SELW'(k);
      if (!found && mask[idx]) begin
        found = 1'b1;
        hit = idx;
      end
    end
    if (cnt_q != 8'd0 && !src_empty[ptr_q]) begin
      found = 1'b1;
      hit = ptr_q;
    end
  end
  // next-state and registered-output computation
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    sel_d = sel_q;
    cnt_d = cnt_q;
    cnt_inc = cnt_q + 8'd1;
    src_read_d = '0;
    out_valid_d = out_valid_q;
    out_data_d = out_data_q;
    out_src_d = out_src_q;
    case (state_q)
      IDLE: if (found) begin
        sel_d = hit;
        src_read_d[hit] = 1'b1;
        cnt_d = (hit == ptr_q) ? cnt_q : 8'd0;
        state_d = FETCH;
      end
      FETCH: state_d = CAPT;
      CAPT: begin
        out_data_d = src_rdata[sel_q*WIDTH +: WIDTH];
        out_src_d = sel_q;
        out_valid_d = 1'b1;
        state_d = HOLD;
      end
      default: if (out_ready) begin
        out_valid_d = 1'b0;
        cnt_d = (cnt_inc == 8'(BURST)) ? 8'd0 : cnt_inc;
        ptr_d = (cnt_inc == 8'(BURST)) ? sel_q + 1'b1 : sel_q;
        state_d = IDLE;
      end
    endcase
    busy_d = state_d != IDLE;
  end
  // state and output registers, cleared asynchronously so src_read drops with reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      sel_q <= '0;
      cnt_q <= '0;
      src_read_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_src_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
      src_read_q <= src_read_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_src_q <= out_src_d;
      busy_q <= busy_d;
    end
  end
  assign src_read = src_read_q;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_src = out_src_q;
  assign busy = busy_q;
endmodule
